// File: rtl/dcache_pkg.sv
// Shared types for the direct-mapped write-back data cache.
// FSM state encoding and address-width constant used by dcache and dcache_array.
// No logic lives here; consumers import dcache_pkg::*.
package dcache_pkg;

    localparam int DC_ADDR_W = 32;

    typedef enum logic [1:0] {
        DC_IDLE      = 2'd0,
        DC_WRITEBACK = 2'd1,
        DC_ALLOCATE  = 2'd2
    } dc_state_t;

endpackage

// File: rtl/dcache_array.sv
// Line storage for dcache: valid/dirty/tag/data per index.
// Latency: reads are combinational by index; writes land at the clock edge.
// Backpressure: none; the controller sequences all writes.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic                  o_rd_dirty,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic [WIDTH-1:0]      o_rd_data,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic                  i_wr_data_en,
    input  logic                  i_wr_tag_en,
    input  logic                  i_wr_dirty_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic                  i_wr_dirty
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [WIDTH-1:0]    r_data [LINES];

    // Status bits: cleared asynchronously; writing a tag makes the line valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_wr_tag_en)   r_valid[i_wr_index] <= 1'b1;
            if (i_wr_dirty_en) r_dirty[i_wr_index] <= i_wr_dirty;
        end
    end

    // Payload storage needs no reset: it is meaningless until valid is set
    always_ff @(posedge clk) begin
        if (i_wr_data_en) r_data[i_wr_index] <= i_wr_data;
        if (i_wr_tag_en)  r_tag[i_wr_index]  <= i_wr_tag;
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_dirty = r_dirty[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back write-allocate data cache; optional DCACHE_STATS_EN adds hit/miss counters.
// Latency: hits complete in the request cycle; misses cost MEM_LATENCY+1 (clean) or 2*MEM_LATENCY+1 (dirty).
// Backpressure: cpu_stall freezes the pipeline, which holds its request stable until stall drops.
module dcache
    import dcache_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DC_ADDR_W-1:0] cpu_addr,
    input  logic [WIDTH-1:0]     cpu_wdata,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    output logic [WIDTH-1:0]     cpu_rdata,
    output logic                 cpu_stall,
    output logic [DC_ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic                 mem_read,
    output logic                 mem_write
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);

    localparam int TAG_BITS = DC_ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    dc_state_t              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [DC_ADDR_W-1:0]   r_mem_addr;
    logic [WIDTH-1:0]       r_mem_wdata;
    logic                   r_mem_read;
    logic                   r_mem_write;

    logic [TAG_BITS-1:0]    w_tag;
    logic [INDEX_BITS-1:0]  w_index;
    logic                   w_valid;
    logic                   w_dirty;
    logic [TAG_BITS-1:0]    w_rd_tag;
    logic [WIDTH-1:0]       w_rd_data;
    logic                   w_req;
    logic                   w_hit;
    logic                   w_idle;
    logic                   w_idle_hit;
    logic                   w_idle_miss;
    logic                   w_store;
    logic                   w_fill;
    logic [DC_ADDR_W-1:0]   w_alloc_addr;

    assign w_tag        = cpu_addr[DC_ADDR_W-1 -: TAG_BITS];
    assign w_index      = cpu_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_req        = cpu_read | cpu_write;
    assign w_hit        = w_valid && (w_rd_tag == w_tag);
    assign w_idle       = (r_state == DC_IDLE);
    assign w_idle_hit   = w_idle && w_req && w_hit;
    assign w_idle_miss  = w_idle && w_req && !w_hit;
    // A write wins over a simultaneous read, so read data is only returned for pure loads
    assign w_store      = w_idle_hit && cpu_write;
    assign w_fill       = (r_state == DC_ALLOCATE) && (r_cnt == CNT_LAST);
    assign w_alloc_addr = {cpu_addr[DC_ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    assign cpu_stall = w_idle_miss || !w_idle;
    assign cpu_rdata = (w_idle_hit && cpu_read && !cpu_write) ? w_rd_data : '0;

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;

    dcache_array #(
        .WIDTH      (WIDTH),
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk           (clk),
        .reset         (reset),
        .i_rd_index    (w_index),
        .o_rd_valid    (w_valid),
        .o_rd_dirty    (w_dirty),
        .o_rd_tag      (w_rd_tag),
        .o_rd_data     (w_rd_data),
        .i_wr_index    (w_index),
        .i_wr_data_en  (w_store | w_fill),
        .i_wr_tag_en   (w_fill),
        .i_wr_dirty_en (w_store | w_fill),
        .i_wr_data     (w_fill ? mem_rdata : cpu_wdata),
        .i_wr_tag      (w_tag),
        .i_wr_dirty    (w_store)
    );

    // Miss FSM: memory strobes/address/data are registered and set up on state entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= DC_IDLE;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            case (r_state)
                DC_IDLE: begin
                    r_cnt <= '0;
                    if (w_idle_miss) begin
                        if (w_valid && w_dirty) begin
                            r_state     <= DC_WRITEBACK;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {w_rd_tag, w_index, {OFFSET_BITS{1'b0}}};
                            r_mem_wdata <= w_rd_data;
                        end else begin
                            r_state    <= DC_ALLOCATE;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= w_alloc_addr;
                        end
                    end
                end
                DC_WRITEBACK: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt       <= '0;
                        r_state     <= DC_ALLOCATE;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_mem_addr  <= w_alloc_addr;
                        r_mem_wdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DC_ALLOCATE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt      <= '0;
                        r_state    <= DC_IDLE;
                        r_mem_read <= 1'b0;
                        r_mem_addr <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= DC_IDLE;
                    r_cnt       <= '0;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic r_after_fill;

    // Count first-presentation hits and misses; the replay hit after a refill belongs to the miss
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count    <= '0;
            miss_count   <= '0;
            r_after_fill <= 1'b0;
        end else begin
            r_after_fill <= w_fill;
            if (w_idle_hit && !r_after_fill) hit_count  <= hit_count + 32'd1;
            if (w_idle_miss)                 miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
